// File: rtl/pulse_param_rx_pkg.sv
// Shared definitions for the host-to-pulse-sequencer parameter link.
// Reset defaults here are also the pulse generator's power-up parameters.
package pulse_param_rx_pkg;

  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_LEN   = 11;
  localparam int         PAYLOAD_LEN = FRAME_LEN - 2;

  localparam logic [7:0]  DEF_PER   = 8'd1;
  localparam logic [15:0] DEF_P1WID = 16'd30;
  localparam logic [15:0] DEF_DEL   = 16'd200;
  localparam logic [15:0] DEF_P2WID = 16'd30;
  localparam logic [7:0]  DEF_P_BL  = 8'd50;
  localparam logic        DEF_PU    = 1'b1;
  localparam logic        DEF_CP    = 1'b1;
  localparam logic        DEF_BL    = 1'b1;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_FRAMING  = 2'd1,
    ERR_CHECKSUM = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    PS_HUNT,
    PS_PAYLOAD,
    PS_CHECK
  } parse_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  typedef struct packed {
    logic [7:0]  per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [7:0]  p_bl;
    logic        bl;
    logic        cp;
    logic        pu;
  } params_t;

  function automatic params_t params_default();
    params_t p;
    p.per   = DEF_PER;
    p.p1wid = DEF_P1WID;
    p.del   = DEF_DEL;
    p.p2wid = DEF_P2WID;
    p.p_bl  = DEF_P_BL;
    p.bl    = DEF_BL;
    p.cp    = DEF_CP;
    p.pu    = DEF_PU;
    return p;
  endfunction

endpackage

// File: rtl/pulse_param_rx_if.sv
// Serial input and parameter/status outputs of the host command receiver.
interface pulse_param_rx_if;
  logic        uart_rx;
  logic [7:0]  per;
  logic [15:0] p1wid;
  logic [15:0] del;
  logic [15:0] p2wid;
  logic [7:0]  p_bl;
  logic        pu;
  logic        cp;
  logic        bl;
  logic        frame_stb;
  logic        err_stb;
  logic [1:0]  err_code;

  modport master (
    output uart_rx,
    input  per, p1wid, del, p2wid, p_bl, pu, cp, bl, frame_stb, err_stb, err_code
  );

  modport slave (
    input  uart_rx,
    output per, p1wid, del, p2wid, p_bl, pu, cp, bl, frame_stb, err_stb, err_code
  );
endinterface

// File: rtl/pulse_param_rx_uart_rx_byte.sv
// 8N1 byte receiver: synchronises the raw line, then samples mid-bit using a
// down-counting bit timer.
module uart_rx_byte
  import pulse_param_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk_pll,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] data,
  output logic       byte_vld,
  output logic       byte_err
);

  // state    | meaning
  // RX_IDLE  | line idle, waiting for a falling edge
  // RX_START | timing to mid start bit, abort on glitch
  // RX_DATA  | sampling 8 data bits, LSB first
  // RX_STOP  | sampling stop bit
  // RX_BREAK | framing error seen, waiting for the line to return high

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

  rx_state_e        state;
  logic             rx_meta;
  logic             rx_sync;
  logic             rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;

  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      state    <= RX_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      data     <= '0;
      byte_vld <= 1'b0;
      byte_err <= 1'b0;
    end else begin
      rx_meta  <= uart_rx;
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      byte_vld <= 1'b0;
      byte_err <= 1'b0;
      case (state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state   <= RX_START;
            cnt     <= HALF_LOAD;
            bit_cnt <= '0;
          end
        end
        RX_START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!rx_sync) begin
            state <= RX_DATA;
            cnt   <= FULL_LOAD;
          end else begin
            state <= RX_IDLE;
          end
        end
        RX_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shift <= {rx_sync, shift[7:1]};
            cnt   <= FULL_LOAD;
            if (bit_cnt == 3'd7) begin
              state <= RX_STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        RX_STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rx_sync) begin
            data     <= shift;
            byte_vld <= 1'b1;
            state    <= RX_IDLE;
          end else begin
            byte_err <= 1'b1;
            state    <= RX_BREAK;
          end
        end
        RX_BREAK: begin
          if (rx_sync) begin
            state <= RX_IDLE;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pulse_param_rx.sv
// Host command receiver: parses checksummed 11-byte parameter frames from the
// UART and loads the pulse generator's parameter registers.
module pulse_param_rx
  import pulse_param_rx_pkg::*;
#(
  parameter int CLK_HZ       = 201_000_000,
  parameter int BAUD         = 115200,
  parameter int TIMEOUT_BITS = 20
) (
  input logic             clk_pll,
  input logic             reset,
  pulse_param_rx_if.slave bus
);

  // state      | meaning
  // PS_HUNT    | discarding bytes until the sync byte
  // PS_PAYLOAD | collecting payload bytes idx 0..8 into the shadow set
  // PS_CHECK   | next byte is the checksum; commit or reject

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int GAP_CLKS     = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int GAP_W        = $clog2(GAP_CLKS + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CLKS);
  localparam logic [3:0]       IDX_LAST = 4'(PAYLOAD_LEN - 1);

  logic [7:0]       rx_data;
  logic             byte_vld;
  logic             byte_err;

  parse_state_e     state;
  logic [3:0]       idx;
  logic [7:0]       chk_acc;
  logic [GAP_W-1:0] gap;
  logic             timeout;
  params_t          shadow;
  params_t          params;
  logic             commit_pend;
  logic             frame_stb_q;
  logic             err_stb_q;
  err_code_e        err_q;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_pll (clk_pll),
    .reset   (reset),
    .uart_rx (bus.uart_rx),
    .data    (rx_data),
    .byte_vld(byte_vld),
    .byte_err(byte_err)
  );

  // gap is a down-counter reloaded per byte; reaching zero mid-frame means the gap overran
  assign timeout = (state != PS_HUNT) && (gap == '0);

  always_ff @(posedge clk_pll) begin
    if (!reset) begin
      state       <= PS_HUNT;
      idx         <= '0;
      chk_acc     <= '0;
      gap         <= '0;
      shadow      <= params_default();
      params      <= params_default();
      commit_pend <= 1'b0;
      frame_stb_q <= 1'b0;
      err_stb_q   <= 1'b0;
      err_q       <= ERR_NONE;
    end else begin
      commit_pend <= 1'b0;
      frame_stb_q <= commit_pend;
      err_stb_q   <= 1'b0;

      if (byte_vld) begin
        gap <= GAP_LOAD;
      end else if (gap != '0) begin
        gap <= gap - 1'b1;
      end

      if (timeout) begin
        state     <= PS_HUNT;
        err_q     <= ERR_TIMEOUT;
        err_stb_q <= 1'b1;
      end else if (byte_err) begin
        state     <= PS_HUNT;
        err_q     <= ERR_FRAMING;
        err_stb_q <= 1'b1;
      end else if (byte_vld) begin
        case (state)
          PS_HUNT: begin
            if (rx_data == SYNC_BYTE) begin
              state   <= PS_PAYLOAD;
              idx     <= '0;
              chk_acc <= '0;
            end
          end
          PS_PAYLOAD: begin
            chk_acc <= chk_acc ^ rx_data;
            case (idx)
              4'd0: shadow.per          <= rx_data;
              4'd1: shadow.p1wid[15:8]  <= rx_data;
              4'd2: shadow.p1wid[7:0]   <= rx_data;
              4'd3: shadow.del[15:8]    <= rx_data;
              4'd4: shadow.del[7:0]     <= rx_data;
              4'd5: shadow.p2wid[15:8]  <= rx_data;
              4'd6: shadow.p2wid[7:0]   <= rx_data;
              4'd7: shadow.p_bl         <= rx_data;
              default: {shadow.bl, shadow.cp, shadow.pu} <= rx_data[2:0];
            endcase
            if (idx == IDX_LAST) begin
              state <= PS_CHECK;
            end else begin
              idx <= idx + 1'b1;
            end
          end
          PS_CHECK: begin
            state <= PS_HUNT;
            if (rx_data == chk_acc) begin
              params      <= shadow;
              commit_pend <= 1'b1;
              err_q       <= ERR_NONE;
            end else begin
              err_q     <= ERR_CHECKSUM;
              err_stb_q <= 1'b1;
            end
          end
          default: state <= PS_HUNT;
        endcase
      end
    end
  end

  assign bus.per       = params.per;
  assign bus.p1wid     = params.p1wid;
  assign bus.del       = params.del;
  assign bus.p2wid     = params.p2wid;
  assign bus.p_bl      = params.p_bl;
  assign bus.pu        = params.pu;
  assign bus.cp        = params.cp;
  assign bus.bl        = params.bl;
  assign bus.frame_stb = frame_stb_q;
  assign bus.err_stb   = err_stb_q;
  assign bus.err_code  = err_q;

endmodule

// File: tb/tb_pulse_param_rx.sv
// Bench for pulse_param_rx: serialised frames in, scoreboard of expected
// commits/errors checked by an independent strobe monitor.
module tb_pulse_param_rx;

  localparam int CPB = 16;

  logic clk_pll = 1'b0;
  logic reset   = 1'b0;

  pulse_param_rx_if bus();

  pulse_param_rx #(
    .CLK_HZ      (16),
    .BAUD        (1),
    .TIMEOUT_BITS(20)
  ) dut (
    .clk_pll(clk_pll),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_pll = ~clk_pll;

  int cyc = 0;
  always @(posedge clk_pll) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [7:0]  per;
    logic [15:0] p1wid;
    logic [15:0] del;
    logic [15:0] p2wid;
    logic [7:0]  p_bl;
    logic [2:0]  flags;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        m;
  logic [1:0] m_err;
  logic [7:0] pl[9];
  int         last_stop_cyc = 0;

  task automatic check(input string name, input logic [66:0] act, input logic [66:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [66:0] vec_of(input ev_t e);
    return {e.per, e.p1wid, e.del, e.p2wid, e.p_bl, e.flags};
  endfunction

  function automatic logic [66:0] dut_vec();
    return {bus.per, bus.p1wid, bus.del, bus.p2wid, bus.p_bl, bus.bl, bus.cp, bus.pu};
  endfunction

  task automatic model_defaults();
    m.is_err = 0;
    m.code   = 0;
    m.per    = 8'd1;
    m.p1wid  = 16'd30;
    m.del    = 16'd200;
    m.p2wid  = 16'd30;
    m.p_bl   = 8'd50;
    m.flags  = 3'b111;
    m_err    = 2'd0;
  endtask

  // monitor: pops the scoreboard on each strobe
  logic [66:0] prev_vec = '0;
  ev_t         mon_e;
  always @(negedge clk_pll) begin
    if (reset) begin
      if (bus.frame_stb) begin
        check("frame_stb_expected", 67'(exp_q.size() != 0), 67'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("frame_stb_kind", 67'(mon_e.is_err), 67'd0);
          check("frame_params", dut_vec(), vec_of(mon_e));
          check("params_loaded_before_stb", prev_vec, vec_of(mon_e));
          check("commit_clears_err_code", 67'(bus.err_code), 67'd0);
          check("frame_stb_latency", 67'(cyc - last_stop_cyc), 67'd13);
        end
      end
      if (bus.err_stb) begin
        check("err_stb_expected", 67'(exp_q.size() != 0), 67'd1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("err_stb_kind", 67'(mon_e.is_err), 67'd1);
          check("err_code", 67'(bus.err_code), 67'(mon_e.code));
          check("params_unchanged_on_err", dut_vec(), vec_of(mon_e));
        end
      end
    end
    prev_vec = dut_vec();
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    bus.uart_rx = 1'b0;
    repeat (CPB) @(negedge clk_pll);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = b[i];
      repeat (CPB) @(negedge clk_pll);
    end
    bus.uart_rx   = stop_bit;
    last_stop_cyc = cyc;
    repeat (CPB) @(negedge clk_pll);
    bus.uart_rx = 1'b1;
    repeat ($urandom_range(0, CPB)) @(negedge clk_pll);
  endtask

  task automatic push_err(input logic [1:0] code);
    ev_t e;
    e        = m;
    e.is_err = 1;
    e.code   = code;
    m_err    = code;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input bit bad_chk);
    logic [7:0] chk;
    ev_t        e;
    chk = 8'h00;
    for (int i = 0; i < 9; i++) chk = chk ^ pl[i];
    if (bad_chk) begin
      push_err(2'd2);
    end else begin
      m.per   = pl[0];
      m.p1wid = pl[1] * 16'd256 + 16'(pl[2]);
      m.del   = pl[3] * 16'd256 + 16'(pl[4]);
      m.p2wid = pl[5] * 16'd256 + 16'(pl[6]);
      m.p_bl  = pl[7];
      m.flags = 3'(pl[8] % 8);
      m_err   = 2'd0;
      e        = m;
      e.is_err = 0;
      exp_q.push_back(e);
    end
    send_byte(8'hA5);
    for (int i = 0; i < 9; i++) send_byte(pl[i]);
    send_byte(bad_chk ? (chk ^ 8'h01) : chk);
  endtask

  initial begin
    logic [7:0] junk;
    bus.uart_rx = 1'b1;
    model_defaults();
    repeat (5) @(negedge clk_pll);
    reset = 1'b1;
    repeat (40) @(negedge clk_pll);
    check("reset_params", dut_vec(), vec_of(m));
    check("reset_err_code", 67'(bus.err_code), 67'd0);
    check("reset_frame_stb", 67'(bus.frame_stb), 67'd0);

    pl = '{8'h05, 8'h00, 8'h3C, 8'h01, 8'h90, 8'h00, 8'h3C, 8'h28, 8'h07};
    send_frame(0);
    check("example_per", 67'(bus.per), 67'd5);
    check("example_del", 67'(bus.del), 67'd400);

    send_frame(1);
    check("bad_chk_err_code", 67'(bus.err_code), 67'd2);

    send_byte(8'h00);
    send_byte(8'hFF);
    pl[0] = 8'h09;
    send_frame(0);

    push_err(2'd3);
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h00);
    repeat (30 * CPB) @(negedge clk_pll);
    check("timeout_err_code", 67'(bus.err_code), 67'(m_err));
    pl[7] = 8'h11;
    send_frame(0);

    push_err(2'd1);
    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h3C, 1'b0);
    repeat (2 * CPB) @(negedge clk_pll);
    check("framing_err_code", 67'(bus.err_code), 67'd1);

    bus.uart_rx = 1'b0;
    repeat (4) @(negedge clk_pll);
    bus.uart_rx = 1'b1;
    repeat (12 * CPB) @(negedge clk_pll);
    check("glitch_err_code_sticky", 67'(bus.err_code), 67'(m_err));

    send_byte(8'hA5);
    send_byte(8'h05);
    send_byte(8'h00);
    reset = 1'b0;
    repeat (3) @(negedge clk_pll);
    reset = 1'b1;
    model_defaults();
    repeat (4) @(negedge clk_pll);
    check("midframe_reset_params", dut_vec(), vec_of(m));
    check("midframe_reset_err_code", 67'(bus.err_code), 67'd0);
    pl[8] = 8'hFA;
    send_frame(0);

    for (int n = 0; n < 12; n++) begin
      int mode;
      for (int i = 0; i < 9; i++) pl[i] = 8'($urandom);
      mode = $urandom_range(0, 9);
      if (mode == 2) begin
        junk = 8'($urandom);
        if (junk == 8'hA5) junk = 8'h5A;
        send_byte(junk);
      end
      send_frame(mode < 2);
      check("random_err_code", 67'(bus.err_code), 67'(m_err));
    end

    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk_pll);
    check("scoreboard_drained", 67'(exp_q.size()), 67'd0);
    check("final_params", dut_vec(), vec_of(m));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
